// File: rtl/frame_scheduler.sv
// Frame sequencer for the 160x120 game: owns ship positions, paces frames, clears and steps the bullet grid.
// Latency: start -> CLEAR next cycle; each frame is tick wait + UPDATE + STEP + SWEEP_CYCLES of DRAW.
// Backpressure: none; a frame tick that arrives while one is still pending is flagged on the sticky overrun output.
module frame_scheduler #(
    parameter int TICKS_PER_FRAME   = 833333,
    parameter int SWEEP_CYCLES      = 19481,
    parameter int ENEMY_STEP_FRAMES = 4,
    parameter int X_MAX             = 159,
    parameter int Y_MAX             = 119
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        move_up,
    input  logic        move_down,
    input  logic        game_over,
    output logic        startGameEn,
    output logic [7:0]  user_x,
    output logic [6:0]  user_y,
    output logic [7:0]  enemy_x,
    output logic [6:0]  enemy_y,
    output logic        bullet_step,
    output logic        draw_busy,
    output logic        overrun,
    output logic [15:0] frame_count,
    output logic [2:0]  state
);

    localparam int TW = $clog2(TICKS_PER_FRAME + 1);
    localparam int SW = $clog2(SWEEP_CYCLES + 1);
    localparam int DW = $clog2(ENEMY_STEP_FRAMES + 1);

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_FRAME - 1);
    localparam logic [SW-1:0] SWEEP_LOAD = SW'(SWEEP_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(ENEMY_STEP_FRAMES - 1);
    localparam logic [7:0]    X_LIM      = 8'(X_MAX);
    localparam logic [6:0]    Y_LIM      = 7'(Y_MAX);

    localparam logic [7:0] USER_X0  = 8'd80;
    localparam logic [6:0] USER_Y0  = 7'd110;
    localparam logic [7:0] ENEMY_X0 = 8'd80;
    localparam logic [6:0] ENEMY_Y0 = 7'd10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_WAIT_TICK = 3'd2,
        ST_UPDATE    = 3'd3,
        ST_STEP      = 3'd4,
        ST_DRAW      = 3'd5,
        ST_OVER      = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic            tick_pending_q, tick_pending_d;
    logic            overrun_q, overrun_d;
    logic [SW-1:0]   sweep_q, sweep_d;
    logic [7:0]      user_x_q, user_x_d;
    logic [6:0]      user_y_q, user_y_d;
    logic [7:0]      enemy_x_q, enemy_x_d;
    logic            enemy_dir_q, enemy_dir_d;   // 1 = moving right
    logic [DW-1:0]   div_q, div_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;

    logic            tick_wrap;
    logic            tick_take;
    logic            start_acc;

    // Candidate positions for this frame's UPDATE, all derived from pre-update values.
    logic [7:0]      ux_upd;
    logic [6:0]      uy_upd;
    logic [7:0]      ex_upd;
    logic            dir_upd;
    logic [DW-1:0]   div_upd;
    logic            hit;

    assign tick_wrap = (tick_cnt_q == TICK_LAST);
    assign tick_take = (state_q == ST_WAIT_TICK) && tick_pending_q;
    assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_OVER));

    // Tick timer, pending flag and sticky overrun flag; a new tick beats consumption.
    always_comb begin
        tick_cnt_d     = tick_wrap ? '0 : tick_cnt_q + 1'b1;
        tick_pending_d = tick_pending_q;
        overrun_d      = overrun_q;
        if (tick_take) begin
            tick_pending_d = 1'b0;
        end
        if (tick_wrap) begin
            tick_pending_d = 1'b1;
        end
        if (start_acc) begin
            overrun_d = 1'b0;
        end
        if (tick_wrap && tick_pending_q && !tick_take) begin
            overrun_d = 1'b1;
        end
    end

    // Per-frame movement rules: bounded user moves, divided enemy patrol with edge bounce.
    always_comb begin
        ux_upd  = user_x_q;
        uy_upd  = user_y_q;
        ex_upd  = enemy_x_q;
        dir_upd = enemy_dir_q;
        div_upd = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

        if (move_left && !move_right && (user_x_q != 8'd0)) begin
            ux_upd = user_x_q - 8'd1;
        end else if (move_right && !move_left && (user_x_q < X_LIM)) begin
            ux_upd = user_x_q + 8'd1;
        end

        if (move_up && !move_down && (user_y_q != 7'd0)) begin
            uy_upd = user_y_q - 7'd1;
        end else if (move_down && !move_up && (user_y_q < Y_LIM)) begin
            uy_upd = user_y_q + 7'd1;
        end

        if (div_q == DIV_LAST) begin
            if (enemy_dir_q) begin
                if (enemy_x_q >= X_LIM) begin
                    dir_upd = 1'b0;
                    ex_upd  = enemy_x_q - 8'd1;
                end else begin
                    ex_upd  = enemy_x_q + 8'd1;
                end
            end else begin
                if (enemy_x_q == 8'd0) begin
                    dir_upd = 1'b1;
                    ex_upd  = enemy_x_q + 8'd1;
                end else begin
                    ex_upd  = enemy_x_q - 8'd1;
                end
            end
        end

        hit = (ux_upd == ex_upd) && (uy_upd == ENEMY_Y0);
    end

    // Sequencer next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        user_x_d    = user_x_q;
        user_y_d    = user_y_q;
        enemy_x_d   = enemy_x_q;
        enemy_dir_d = enemy_dir_q;
        div_d       = div_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d     = ST_CLEAR;
                    sweep_d     = SWEEP_LOAD;
                    user_x_d    = USER_X0;
                    user_y_d    = USER_Y0;
                    enemy_x_d   = ENEMY_X0;
                    enemy_dir_d = 1'b1;
                    div_d       = '0;
                    frame_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (sweep_q == '0) begin
                    state_d = ST_WAIT_TICK;
                end else begin
                    sweep_d = sweep_q - 1'b1;
                end
            end
            ST_WAIT_TICK: begin
                if (tick_pending_q) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                user_x_d    = ux_upd;
                user_y_d    = uy_upd;
                enemy_x_d   = ex_upd;
                enemy_dir_d = dir_upd;
                div_d       = div_upd;
                state_d     = (game_over || hit) ? ST_OVER : ST_STEP;
            end
            ST_STEP: begin
                state_d = ST_DRAW;
                sweep_d = SWEEP_LOAD;
            end
            ST_DRAW: begin
                if (sweep_q == '0) begin
                    state_d     = ST_WAIT_TICK;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    sweep_d = sweep_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register bank with asynchronous reset to the power-up game layout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            tick_cnt_q     <= '0;
            tick_pending_q <= 1'b0;
            overrun_q      <= 1'b0;
            sweep_q        <= '0;
            user_x_q       <= USER_X0;
            user_y_q       <= USER_Y0;
            enemy_x_q      <= ENEMY_X0;
            enemy_dir_q    <= 1'b1;
            div_q          <= '0;
            frame_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            tick_pending_q <= tick_pending_d;
            overrun_q      <= overrun_d;
            sweep_q        <= sweep_d;
            user_x_q       <= user_x_d;
            user_y_q       <= user_y_d;
            enemy_x_q      <= enemy_x_d;
            enemy_dir_q    <= enemy_dir_d;
            div_q          <= div_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    // The clear pulse marks the first CLEAR cycle, identified by the freshly loaded sweep count.
    assign startGameEn = (state_q == ST_CLEAR) && (sweep_q == SWEEP_LOAD);
    assign bullet_step = (state_q == ST_STEP);
    assign draw_busy   = (state_q == ST_CLEAR) || (state_q == ST_DRAW);
    assign overrun     = overrun_q;
    assign user_x      = user_x_q;
    assign user_y      = user_y_q;
    assign enemy_x     = enemy_x_q;
    assign enemy_y     = ENEMY_Y0;
    assign frame_count = frame_cnt_q;
    assign state       = state_q;

endmodule
